tt_um_irrationalanalysis_prbs31_checker: RTL and testbench
==========================================================

// Module: tt_um_irrationalanalysis_prbs31_checker
// PURPOSE
//   Receive-side partner of the team's byte-parallel PRBS31 generator (x^31 + x^28 + 1).
//   Accepts one 8-bit word per qualified clock on ui_in and self-synchronises to the sequence.
//   Once locked, it free-runs a local PRBS31 model and counts bit errors.
//   Sits as a standalone TT tile: pattern on ui_in, control on uio_in, status and counters on uo_out.
// PARAMETERS
//   LOCK_BYTES  8   consecutive error-free bytes needed to declare lock (1..255)
//   UNLOCK_WIN  16  length, in accepted bytes, of the loss-of-lock window (2..255)
//   UNLOCK_THR  4   errored bytes within one window that force loss of lock (1..UNLOCK_WIN)
//   ERR_W       24  bit-error counter width (fixed at 24 for the uo_out read map)
// PORTS
//   clk      in   1  clock
//   rst_n    in   1  asynchronous active-low reset
//   ena      in   1  tile enable; low = valid and clear forced to 0, all state held
//   ui_in    in   8  received PRBS byte; ui_in[7] is earliest in time, ui_in[0] latest
//   uio_in   in   8  [0] valid; [1] clear (synchronous); [3:2] read select; [7:4] ignored
//   uo_out   out  8  read mux: sel0 {locked, err_sat, loss_cnt[5:0]}; sel1 err[7:0]; sel2 err[15:8]; sel3 err[23:16]
//   uio_out  out  8  constant 0
//   uio_oe   out  8  constant 0 (all uio pins are inputs)
// BEHAVIOUR
//   - Reset values: hist = 0, state = SEARCH, fill = 0, good = 0, err = 0, err_sat = 0, loss_cnt = 0, window counters = 0.
//     uo_out therefore reads 0 for every select.
//   - hist[30:0] holds the 31 most recent bits; hist[0] is the newest.
//   - Expected byte: exp[7-t] = hist[30-t] ^ hist[27-t], for t = 0..7.
//     Every tap is at least 28 bits old, so exp depends only on prior bytes.
//   - bad = exp ^ ui_in; nerr = popcount(bad), range 0..8.
//   - All updates occur only on an accepted byte (valid & ena); otherwise every register holds.
//   - SEARCH:
//     - hist <= {hist[22:0], ui_in}.
//     - fill counts 0..4 and saturates at 4; no comparison is made while fill < 4.
//     - With fill == 4: if nerr == 0 and hist != 0, good++; otherwise good = 0.
//       The hist != 0 guard prevents lock on an all-zero stream.
//     - When good reaches LOCK_BYTES on an accepted byte -> LOCKED, with the window counters zeroed.
//   - LOCKED:
//     - hist <= {hist[22:0], exp}. The local model free-runs, so each line error is counted once
//       and is not multiplied.
//     - err <= err + nerr, saturating at 2^ERR_W - 1; err_sat is set when saturation occurs and is sticky.
//     - win counts accepted bytes; bad_cnt counts bytes with nerr != 0.
//     - When win reaches UNLOCK_WIN: win and bad_cnt restart at 0.
//     - When bad_cnt reaches UNLOCK_THR: -> SEARCH, fill = 0, good = 0, loss_cnt++ (saturates at 63).
//       The error counter is retained.
//   - Lock transition on byte N: the first comparison against the free-run model is byte N+1.
//   - clear (uio_in[1] & ena):
//     - Zeroes err, err_sat and loss_cnt next edge; state, hist, fill and good are unaffected.
//     - clear beats a simultaneous increment: that byte's nerr is discarded.
//     - A simultaneous loss of lock still moves to SEARCH, but loss_cnt ends at 0.
//   - Latency: status and counters reflect an accepted byte one clock after its edge.
//     uo_out is a combinational mux of registers, so a read-select change is visible the same cycle.
//   - rst_n low at any point (mid-lock, mid-fill) returns immediately to reset values; no partial state survives.
// TESTING
//   - Reset, then 40 clean PRBS31 bytes (seed all-ones, valid=1) -> locked=1 after byte 4+8=12; err=0 at end.
//   - Locked stream with bit 3 of one byte flipped -> err=1 on sel1, locked stays 1.
//     Next byte matches, i.e. no error multiplication.
//   - Locked stream with 0xFF XOR on 4 bytes within 16 -> err=32, locked=0, loss_cnt=1.
//     Then relocks 12 clean bytes later.
//   - 64 bytes of 0x00 from reset -> locked never 1, err=0.
//   - Valid toggled 0/1 every other cycle on a clean stream -> lock at accepted byte 12; gaps never count as bytes.
//   - Hold clear high together with an errored locked byte -> err=0, err_sat=0.
//     Assert rst_n low while locked -> all sel reads 0 and state is SEARCH.

Source files
------------

// File: rtl/tt_um_irrationalanalysis_prbs31_checker.sv
// PRBS31 (x^31 + x^28 + 1) byte-parallel receive checker.
// Self-synchronises on ui_in, then free-runs a local model and counts bit errors.
module tt_um_irrationalanalysis_prbs31_checker #(
    parameter int LOCK_BYTES = 8,
    parameter int UNLOCK_WIN = 16,
    parameter int UNLOCK_THR = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int ERR_W = 24;
    localparam logic [7:0] LOCK_N = 8'(LOCK_BYTES);
    localparam logic [7:0] WIN_N = 8'(UNLOCK_WIN);
    localparam logic [7:0] THR_N = 8'(UNLOCK_THR);

    typedef enum logic {
        SEARCH,
        LOCKED
    } state_t;

    state_t           state;
    logic [30:0]      hist;
    logic [2:0]       fill;
    logic [7:0]       good;
    logic [7:0]       win;
    logic [7:0]       bad_cnt;
    logic [ERR_W-1:0] err;
    logic             err_sat;
    logic [5:0]       loss_cnt;

    logic             acc;
    logic             clear;
    logic [1:0]       sel;
    logic [7:0]       exp_byte;
    logic [7:0]       bad;
    logic [3:0]       nerr;
    logic             match;
    logic             cmp_en;
    logic [7:0]       good_inc;
    logic [7:0]       win_inc;
    logic [7:0]       bad_inc;
    logic             lock_hit;
    logic             loss_hit;
    logic             win_wrap;
    logic [ERR_W:0]   err_sum;
    logic [ERR_W-1:0] err_next;
    logic             sat_hit;
    logic             unused_ok;

    assign acc       = uio_in[0] & ena;
    assign clear     = uio_in[1] & ena;
    assign sel       = uio_in[3:2];
    assign unused_ok = &{1'b0, uio_in[7:4]};

    // Every tap is at least 21 bits old, so the whole byte comes from history.
    assign exp_byte = hist[30:23] ^ hist[27:20];
    assign bad      = exp_byte ^ ui_in;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    assign nerr = popcount8(bad);

    always_comb begin
        match    = (nerr == 4'd0) && (hist != '0);
        cmp_en   = (fill == 3'd4);
        good_inc = good + 8'd1;
        win_inc  = win + 8'd1;
        bad_inc  = bad_cnt + {7'd0, (nerr != 4'd0)};
        lock_hit = (state == SEARCH) && cmp_en && match
                   && (good_inc == LOCK_N);
        loss_hit = (state == LOCKED) && (bad_inc == THR_N);
        win_wrap = (win_inc == WIN_N);
    end

    always_comb begin
        err_sum  = {1'b0, err} + {{(ERR_W - 3){1'b0}}, nerr};
        sat_hit  = err_sum[ERR_W] | (&err_sum[ERR_W-1:0]);
        err_next = err_sum[ERR_W] ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SEARCH;
            hist    <= '0;
            fill    <= '0;
            good    <= '0;
            win     <= '0;
            bad_cnt <= '0;
        end else if (acc) begin
            unique case (state)
                SEARCH: begin
                    hist <= {hist[22:0], ui_in};
                    if (!cmp_en) begin
                        fill <= fill + 3'd1;
                    end else if (!match) begin
                        good <= '0;
                    end else if (lock_hit) begin
                        state   <= LOCKED;
                        good    <= '0;
                        win     <= '0;
                        bad_cnt <= '0;
                    end else begin
                        good <= good_inc;
                    end
                end
                LOCKED: begin
                    // Free-run on the model so one line error is counted once.
                    hist <= {hist[22:0], exp_byte};
                    if (loss_hit) begin
                        state   <= SEARCH;
                        fill    <= '0;
                        good    <= '0;
                        win     <= '0;
                        bad_cnt <= '0;
                    end else if (win_wrap) begin
                        win     <= '0;
                        bad_cnt <= '0;
                    end else begin
                        win     <= win_inc;
                        bad_cnt <= bad_inc;
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

    // Clear wins over a same-cycle increment or loss count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err      <= '0;
            err_sat  <= 1'b0;
            loss_cnt <= '0;
        end else if (clear) begin
            err      <= '0;
            err_sat  <= 1'b0;
            loss_cnt <= '0;
        end else if (acc && state == LOCKED) begin
            err <= err_next;
            if (sat_hit) begin
                err_sat <= 1'b1;
            end
            if (loss_hit && loss_cnt != 6'd63) begin
                loss_cnt <= loss_cnt + 6'd1;
            end
        end
    end

    always_comb begin
        uo_out = '0;
        unique case (sel)
            2'd0: uo_out = {(state == LOCKED), err_sat, loss_cnt};
            2'd1: uo_out = err[7:0];
            2'd2: uo_out = err[15:8];
            2'd3: uo_out = err[23:16];
            default: uo_out = '0;
        endcase
    end

    assign uio_out = '0;
    assign uio_oe  = '0;

endmodule

// File: tb/tb_tt_um_irrationalanalysis_prbs31_checker.sv
// Directed bench for the PRBS31 checker tile.
// Stream source is a bit-serial x^31 + x^28 + 1 generator seeded all-ones.
module tb_tt_um_irrationalanalysis_prbs31_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b1;
    logic [7:0] ui_in = '0;
    logic [7:0] uio_in = '0;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    logic [30:0] g;
    int          n_chk = 0;
    int          n_fail = 0;

    tt_um_irrationalanalysis_prbs31_checker dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic gen_byte(output logic [7:0] b);
        logic nb;
        for (int t = 0; t < 8; t++) begin
            nb = g[30] ^ g[27];
            b[7-t] = nb;
            g = {g[29:0], nb};
        end
    endtask

    task automatic send(input logic [7:0] x, input logic clr);
        logic [7:0] b;
        gen_byte(b);
        ui_in = b ^ x;
        uio_in[1:0] = {clr, 1'b1};
        @(posedge clk);
        #1;
        uio_in[1:0] = 2'b00;
    endtask

    task automatic idle(input logic [7:0] d, input logic v, input logic e);
        ui_in = d;
        ena = e;
        uio_in[0] = v;
        @(posedge clk);
        #1;
        uio_in[0] = 1'b0;
        ena = 1'b1;
    endtask

    task automatic rd(input logic [1:0] s, output logic [7:0] v);
        uio_in[3:2] = s;
        #1;
        v = uo_out;
    endtask

    task automatic rd_err(output logic [23:0] e);
        logic [7:0] b0, b1, b2;
        rd(2'd1, b0);
        rd(2'd2, b1);
        rd(2'd3, b2);
        e = {b2, b1, b0};
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        ena = 1'b1;
        ui_in = '0;
        uio_in = '0;
        g = '1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0]  v;
        logic [23:0] e;
        logic        seen;

        // Clean stream: lock after byte 12
        do_reset();
        for (int s = 0; s < 4; s++) begin
            rd(2'(s), v);
            check($sformatf("rst_sel%0d", s), 32'(v), 32'h0);
        end
        check("uio_oe", 32'(uio_oe), 32'h0);
        check("uio_out", 32'(uio_out), 32'h0);
        repeat (11) send(8'h00, 1'b0);
        rd(2'd0, v);
        check("nolock_11", 32'(v[7]), 32'h0);
        send(8'h00, 1'b0);
        rd(2'd0, v);
        check("lock_12", 32'(v), 32'h80);
        idle(8'hFF, 1'b1, 1'b0);
        rd_err(e);
        check("ena_hold", 32'(e), 32'h0);
        repeat (28) send(8'h00, 1'b0);
        rd_err(e);
        check("clean_err", 32'(e), 32'h0);

        // Single bit error, no multiplication
        send(8'h08, 1'b0);
        rd_err(e);
        check("bit3_err", 32'(e), 32'h1);
        rd(2'd0, v);
        check("bit3_lock", 32'(v), 32'h80);
        send(8'h00, 1'b0);
        rd_err(e);
        check("no_mult", 32'(e), 32'h1);
        idle(8'h3C, 1'b0, 1'b1);
        rd_err(e);
        check("gap_hold", 32'(e), 32'h1);

        // Loss of lock after 4 errored bytes, then relock
        do_reset();
        repeat (12) send(8'h00, 1'b0);
        repeat (3) send(8'hFF, 1'b0);
        rd(2'd0, v);
        check("loss_pre", 32'(v), 32'h80);
        rd_err(e);
        check("err_24", 32'(e), 32'd24);
        send(8'hFF, 1'b0);
        rd(2'd0, v);
        check("loss_st", 32'(v), 32'h01);
        rd_err(e);
        check("err_32", 32'(e), 32'd32);
        repeat (11) send(8'h00, 1'b0);
        rd(2'd0, v);
        check("relock_11", 32'(v), 32'h01);
        send(8'h00, 1'b0);
        rd(2'd0, v);
        check("relock_12", 32'(v), 32'h81);
        rd_err(e);
        check("err_keep", 32'(e), 32'd32);

        // All-zero stream never locks
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            idle(8'h00, 1'b1, 1'b1);
            rd(2'd0, v);
            if (v[7]) seen = 1'b1;
        end
        check("zero_nolock", 32'(seen), 32'h0);
        rd_err(e);
        check("zero_err", 32'(e), 32'h0);

        // Gapped valid: only accepted bytes count
        do_reset();
        for (int i = 0; i < 11; i++) begin
            send(8'h00, 1'b0);
            idle(8'h5A, 1'b0, 1'b1);
        end
        rd(2'd0, v);
        check("gap_nolock_11", 32'(v[7]), 32'h0);
        send(8'h00, 1'b0);
        rd(2'd0, v);
        check("gap_lock_12", 32'(v[7]), 32'h1);
        idle(8'h5A, 1'b0, 1'b1);
        rd(2'd0, v);
        check("gap_lock_hold", 32'(v[7]), 32'h1);

        // Clear beats an errored byte; async reset while locked
        send(8'hFF, 1'b0);
        rd_err(e);
        check("pre_clr_err", 32'(e), 32'd8);
        send(8'hFF, 1'b1);
        rd_err(e);
        check("clr_err", 32'(e), 32'h0);
        rd(2'd0, v);
        check("clr_st", 32'(v), 32'h80);
        rst_n = 1'b0;
        for (int s = 0; s < 4; s++) begin
            rd(2'(s), v);
            check($sformatf("arst_sel%0d", s), 32'(v), 32'h0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rd(2'd0, v);
        check("arst_search", 32'(v[7]), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
